// File: rtl/bidirection_buf_pkg.sv
// Shared types and constants for the bidirectional pad buffer.
package bidirection_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    A2B  = 2'b01,
    B2A  = 2'b10,
    TURN = 2'b11
  } state_t;

  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/bidir_tristate_cell.sv
// WIDTH-bit tristate driver: dout follows din while en is high, otherwise high-Z.
module bidir_tristate_cell #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output wire  [WIDTH-1:0] dout
);

  assign dout = en ? din : {WIDTH{1'bz}};

endmodule

// File: rtl/bidirection_buf.sv
// Direction-controlled buffer between pads a and b with a high-Z gap on direction change.
// Macro BIDIR_BUF_TURNAROUND_EN enables the TURN state; otherwise direction follows control directly.
module bidirection_buf
  import bidirection_buf_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             control,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  output logic             dir_o,
  output logic             busy_o
);

  if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("TURN_CYCLES must be in 1..15");
  end

  state_t state;
  logic   en_a;
  logic   en_b;

`ifdef BIDIR_BUF_TURNAROUND_EN

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TURN_CYCLES - 1);

  logic             target;
  logic [CNT_W-1:0] cnt;

  // Enables are flops so the pads never see a decode glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      target <= DIR_B2A;
      cnt    <= '0;
      en_a   <= 1'b0;
      en_b   <= 1'b0;
      dir_o  <= DIR_B2A;
      busy_o <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state  <= (control == DIR_A2B) ? A2B : B2A;
          en_b   <= (control == DIR_A2B);
          en_a   <= (control == DIR_B2A);
          dir_o  <= control;
          busy_o <= 1'b0;
        end
        A2B, B2A: begin
          if (control != dir_o) begin
            state  <= TURN;
            target <= control;
            cnt    <= CNT_RELOAD;
            en_a   <= 1'b0;
            en_b   <= 1'b0;
            busy_o <= 1'b1;
          end
        end
        TURN: begin
          if (control != target) begin
            target <= control;
            cnt    <= CNT_RELOAD;
          end else if (cnt == '0) begin
            state  <= (target == DIR_A2B) ? A2B : B2A;
            en_b   <= (target == DIR_A2B);
            en_a   <= (target == DIR_B2A);
            dir_o  <= target;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          en_a   <= 1'b0;
          en_b   <= 1'b0;
          busy_o <= 1'b1;
        end
      endcase
    end
  end

`else

  logic active;

  // IDLE only for the first edge after reset; afterwards control steers the pads directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= (control == DIR_A2B) ? A2B : B2A;
    end
  end

  assign active = (state != IDLE);
  assign en_b   = active & (control == DIR_A2B);
  assign en_a   = active & (control == DIR_B2A);
  assign dir_o  = en_b;
  assign busy_o = ~active;

`endif

  bidir_tristate_cell #(.WIDTH(WIDTH)) u_a2b (
    .en  (en_b),
    .din (a),
    .dout(b)
  );

  bidir_tristate_cell #(.WIDTH(WIDTH)) u_b2a (
    .en  (en_a),
    .din (b),
    .dout(a)
  );

endmodule

// File: tb/tb_bidirection_buf.sv
// Directed bench for bidirection_buf; covers both builds of BIDIR_BUF_TURNAROUND_EN.
module tb_bidirection_buf;

  logic clk;
  logic rst_n;
  logic control;
  logic a_drv, a_en;
  logic b_drv, b_en;
  wire  a;
  wire  b;
  logic dir_o;
  logic busy_o;

  int n_vec = 0;
  int n_err = 0;

  assign a = a_en ? a_drv : 1'bz;
  assign b = b_en ? b_drv : 1'bz;

  bidirection_buf #(.WIDTH(1), .TURN_CYCLES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .control(control),
    .a      (a),
    .b      (b),
    .dir_o  (dir_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #2;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy_o); end
    n_vec++; if (dir_o !== 1'b0) begin n_err++; $display("FAIL reset_dir: got %b want 0", dir_o); end
    a_en = 1'b1; a_drv = 1'b1;
    #1;
    n_vec++; if (b === 1'b1) begin n_err++; $display("FAIL reset_b_hiz: got %b want z", b); end
    a_en = 1'b0; b_en = 1'b1; b_drv = 1'b1;
    #1;
    n_vec++; if (a === 1'b1) begin n_err++; $display("FAIL reset_a_hiz: got %b want z", a); end
    b_en = 1'b0;
  endtask

  task automatic test_a2b();
    @(negedge clk);
    control = 1'b1; a_en = 1'b1; a_drv = 1'b1; rst_n = 1'b1;
    #1;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL idle_busy: got %b want 1", busy_o); end
    n_vec++; if (b === 1'b1) begin n_err++; $display("FAIL idle_b_hiz: got %b want z", b); end
    @(posedge clk); #1;
    n_vec++; if (b !== 1'b1) begin n_err++; $display("FAIL a2b_first: got %b want 1", b); end
    n_vec++; if (dir_o !== 1'b1) begin n_err++; $display("FAIL a2b_dir: got %b want 1", dir_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL a2b_busy: got %b want 0", busy_o); end
    for (int i = 0; i < 4; i++) begin
      a_drv = ~a_drv;
      #1;
      n_vec++; if (b !== a_drv) begin n_err++; $display("FAIL a2b_mirror[%0d]: got %b want %b", i, b, a_drv); end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #2;
    a_drv = 1'b1;
    #1;
    n_vec++; if (b !== 1'b1) begin n_err++; $display("FAIL pre_reset_b: got %b want 1", b); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (b === 1'b1) begin n_err++; $display("FAIL async_rst_b_hiz: got %b want z", b); end
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL async_rst_busy: got %b want 1", busy_o); end
    n_vec++; if (dir_o !== 1'b0) begin n_err++; $display("FAIL async_rst_dir: got %b want 0", dir_o); end
    a_en = 1'b0;
  endtask

`ifdef BIDIR_BUF_TURNAROUND_EN

  task automatic test_turn();
    @(negedge clk);
    control = 1'b1; a_en = 1'b1; a_drv = 1'b1; rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (b !== 1'b1) begin n_err++; $display("FAIL turn_start_b: got %b want 1", b); end
    @(negedge clk);
    control = 1'b0; a_en = 1'b0;
    #1;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL turn_pre_busy: got %b want 0", busy_o); end
    @(posedge clk); #1;
    b_en = 1'b1; b_drv = 1'b1;
    #1;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL turn1_busy: got %b want 1", busy_o); end
    n_vec++; if (dir_o !== 1'b1) begin n_err++; $display("FAIL turn1_dir_hold: got %b want 1", dir_o); end
    n_vec++; if (a === 1'b1) begin n_err++; $display("FAIL turn1_a_hiz: got %b want z", a); end
    @(posedge clk); #1;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL turn2_busy: got %b want 1", busy_o); end
    n_vec++; if (a === 1'b1) begin n_err++; $display("FAIL turn2_a_hiz: got %b want z", a); end
    @(posedge clk); #1;
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL b2a_a: got %b want 1", a); end
    n_vec++; if (dir_o !== 1'b0) begin n_err++; $display("FAIL b2a_dir: got %b want 0", dir_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL b2a_busy: got %b want 0", busy_o); end
    b_drv = 1'b0;
    #1;
    n_vec++; if (a !== 1'b0) begin n_err++; $display("FAIL b2a_zero: got %b want 0", a); end
    b_drv = 1'b1;
  endtask

  task automatic test_retarget();
    @(negedge clk);
    control = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rt1_busy: got %b want 1", busy_o); end
    n_vec++; if (a === 1'b1) begin n_err++; $display("FAIL rt1_a_hiz: got %b want z", a); end
    n_vec++; if (dir_o !== 1'b0) begin n_err++; $display("FAIL rt1_dir_hold: got %b want 0", dir_o); end
    @(negedge clk);
    control = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rt2_busy: got %b want 1", busy_o); end
    n_vec++; if (a === 1'b1) begin n_err++; $display("FAIL rt2_a_hiz: got %b want z", a); end
    @(posedge clk); #1;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rt3_busy: got %b want 1", busy_o); end
    n_vec++; if (a === 1'b1) begin n_err++; $display("FAIL rt3_a_hiz: got %b want z", a); end
    @(posedge clk); #1;
    n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL rt_final_a: got %b want 1", a); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rt_final_busy: got %b want 0", busy_o); end
    n_vec++; if (dir_o !== 1'b0) begin n_err++; $display("FAIL rt_final_dir: got %b want 0", dir_o); end
  endtask

`else

  task automatic test_follow();
    logic [7:0] ctrl_vec;
    logic [7:0] dat0_vec;
    logic [7:0] dat1_vec;
    ctrl_vec = 8'b0100_1101;
    dat0_vec = 8'b1010_0110;
    dat1_vec = 8'b0101_1001;
    @(negedge clk);
    control = 1'b1; a_en = 1'b1; a_drv = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      a_en = 1'b0; b_en = 1'b0;
      control = ctrl_vec[k];
      if (ctrl_vec[k]) a_en = 1'b1; else b_en = 1'b1;
      for (int j = 0; j < 2; j++) begin
        if (ctrl_vec[k]) a_drv = (j == 0) ? dat0_vec[k] : dat1_vec[k];
        else             b_drv = (j == 0) ? dat0_vec[k] : dat1_vec[k];
        #1;
        if (ctrl_vec[k]) begin
          n_vec++; if (b !== a_drv) begin n_err++; $display("FAIL follow_b[%0d.%0d]: got %b want %b", k, j, b, a_drv); end
        end else begin
          n_vec++; if (a !== b_drv) begin n_err++; $display("FAIL follow_a[%0d.%0d]: got %b want %b", k, j, a, b_drv); end
        end
        n_vec++; if (dir_o !== ctrl_vec[k]) begin n_err++; $display("FAIL follow_dir[%0d.%0d]: got %b want %b", k, j, dir_o, ctrl_vec[k]); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL follow_busy[%0d.%0d]: got %b want 0", k, j, busy_o); end
        #24;
      end
    end
    a_en = 1'b0; b_en = 1'b0;
  endtask

`endif

  initial begin
    clk = 1'b0; rst_n = 1'b0; control = 1'b1;
    a_drv = 1'b0; a_en = 1'b0; b_drv = 1'b0; b_en = 1'b0;
    test_reset();
    test_a2b();
    test_async_reset();
`ifdef BIDIR_BUF_TURNAROUND_EN
    test_turn();
    test_retarget();
`else
    test_follow();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bidirection_buf.md
BIDIRECTION_BUF -- requirements
Module: bidirection_buf

Interface
REQ-001 The module SHALL be named bidirection_buf and have one clock and an asynchronous active-low reset.
REQ-002 Parameter WIDTH, default 1: bit width of both bidirectional ports.
REQ-003 Parameter TURN_CYCLES, default 2, range 1..15: number of all-high-Z clock cycles inserted on a direction change.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port control, input, 1 bit: requested direction, synchronous to clk; 1 means a drives b, 0 means b drives a.
REQ-007 Port a, inout, WIDTH bits: side A pad.
REQ-008 Port b, inout, WIDTH bits: side B pad.
REQ-009 Port dir_o, output, 1 bit: effective direction currently enabled; 1 means A-to-B.
REQ-010 Port busy_o, output, 1 bit: high while both sides are high-Z (reset or turnaround).

Function
REQ-011 In state A2B, the module SHALL drive b with the value of a combinationally (zero latency) and hold a at high-Z.
REQ-012 In state B2A, the module SHALL drive a with the value of b combinationally and hold b at high-Z.
REQ-013 In states IDLE and TURN, the module SHALL hold both a and b at high-Z.
REQ-014 The FSM SHALL have the states IDLE, A2B, B2A and TURN.
REQ-015 IDLE SHALL move to A2B if the sampled control is 1, or to B2A if it is 0, on the first clock edge after reset is released.
REQ-016 When control differs from the current direction in A2B or B2A, the FSM SHALL enter TURN on the next edge, with target equal to control and counter equal to TURN_CYCLES-1.
REQ-017 In TURN, the counter SHALL decrement each cycle; at 0, the FSM SHALL enter the state given by the target on the next edge.
REQ-018 If control changes while in TURN, the target SHALL be updated to the new control and the counter SHALL restart at TURN_CYCLES-1.
REQ-019 If the final target equals the pre-turn direction, the full turnaround gap still applies.
REQ-020 Buffers SHALL never drive a and b simultaneously, in any state or in any reset phase.
REQ-021 dir_o SHALL be 1 in A2B and 0 in B2A; in TURN and IDLE it SHALL hold its last value.
REQ-022 busy_o SHALL be 1 in IDLE and TURN, and 0 otherwise.
REQ-023 X or Z values on the driving side SHALL pass through unaltered.

Reset
REQ-024 Asserting rst_n low SHALL immediately force state IDLE, both pads to high-Z, busy_o=1, dir_o=0 and counter=0, independent of clk.
REQ-025 Reset asserted mid-transfer or mid-turnaround SHALL abort that activity immediately with no glitch drive on either pad.

Configuration
REQ-026 With macro BIDIR_BUF_TURNAROUND_EN defined, the module SHALL behave as specified in REQ-016 to REQ-019.
REQ-027 Without BIDIR_BUF_TURNAROUND_EN, the TURN state and counter SHALL be omitted.
REQ-028 Without BIDIR_BUF_TURNAROUND_EN, the direction SHALL follow control combinationally outside reset, and busy_o SHALL be 1 only during reset or IDLE.
REQ-029 Without BIDIR_BUF_TURNAROUND_EN, dir_o SHALL equal control outside IDLE.

Structure
REQ-030 Package bidirection_buf_pkg SHALL hold the FSM state enum (IDLE, A2B, B2A, TURN), the direction constants DIR_A2B=1 and DIR_B2A=0, and the TURN_CYCLES counter width constant 4.
REQ-031 One sub-module, bidir_tristate_cell, SHALL implement a WIDTH-bit tristate driver with an enable input; it SHALL be instantiated twice, once per direction.
REQ-032 The FSM and counter SHALL reside in the top module.

Verification
REQ-033 Reset low, bench drives nothing -> a=Z, b=Z, busy_o=1, dir_o=0.
REQ-034 Release reset with control=1 and bench drive a=1 -> after 1 edge, b=1 in the same delta as a toggles, dir_o=1, busy_o=0.
REQ-035 With the macro on, TURN_CYCLES=2: switch control 1->0 while the bench drives b=0 -> a=Z for exactly 2 cycles with busy_o=1, then a=0 and dir_o=0.
REQ-036 Toggle control 0->1->0 within TURN -> counter restarts, final state B2A, with no cycle where both pads are driven by the DUT.
REQ-037 Assert rst_n low during A2B with a toggling -> b goes to Z asynchronously before the next clk edge.
REQ-038 With the macro off, toggle control every 50 time units while the bench drives a (control=1) or b (control=0) with toggling data -> the opposite pad mirrors it in zero time and is never in contention.
